cp0_intr_ctrl: RTL and testbench

//  Coprocessor-0 interrupt/exception receiver inside CPU, at the M stage. Takes the 6-bit hwint

---
 rtl/cp0_pkg.sv | 33 +++
 rtl/cp0_intr_ctrl.sv | 121 ++++++++++++
 tb/tb_cp0_intr_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, ExcCodes, SR/Cause bit positions.
package cp0_pkg;

    // CP0 register numbers (rd field of mtc0/mfc0)
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // ExcCode values written into Cause[6:2]
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // SR / Cause field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int IM_HI    = 15;
    localparam int IP_LO    = 10;
    localparam int IP_HI    = 15;
    localparam int EXC_LO   = 2;
    localparam int EXC_HI   = 6;
    localparam int CAUSE_BD = 31;

    // EPC always holds a word address
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_intr_ctrl.sv
// CP0 interrupt/exception receiver at the M stage: raises intreq and holds
// SR/Cause/EPC/PRId for mfc0, mtc0 and eret.
module cp0_intr_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_2019,
    parameter int          ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        hwint,
    input  logic [31:0]       pc_m,
    input  logic              bd_m,
    input  logic              exc_valid,
    input  logic [4:0]        exccode,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              eret,
    output logic [31:0]       rdata,
    output logic [31:0]       epc,
    output logic              intreq,
    output logic              exl
);

    // SR fields
    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    // Cause fields
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q;
    // EPC
    logic [31:0] epc_q;

    logic        int_hit;
    logic        exc_hit;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] victim_pc;

    // Live hwint (not IP) decides the interrupt, so it fires in the same cycle
    assign int_hit = (|(hwint & im_q)) & ie_q & ~exl_q;
    assign exc_hit = exc_valid & ~exl_q;
    assign intreq  = int_hit | exc_hit;

    // A flushed victim's mtc0 must never commit
    assign wr_sr  = we & ~intreq & (addr == ADDR_W'(CP0_SR));
    assign wr_epc = we & ~intreq & (addr == ADDR_W'(CP0_EPC));

    // Delay-slot victims restart at the branch; wraps modulo 2^32
    assign victim_pc = bd_m ? (pc_m - 32'd4) : pc_m;

    assign epc = epc_q;
    assign exl = exl_q;

    // SR: entry sets EXL, eret clears it, otherwise mtc0 may load it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else if (intreq) begin
            exl_q <= 1'b1;
        end else if (eret) begin
            exl_q <= 1'b0;
        end else if (wr_sr) begin
            im_q  <= wdata[IM_HI:IM_LO];
            exl_q <= wdata[SR_EXL];
            ie_q  <= wdata[SR_IE];
        end
    end

    // Cause: IP tracks hwint every edge; BD/ExcCode captured on entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= EXC_INT;
        end else begin
            ip_q <= hwint;
            if (intreq) begin
                bd_q  <= bd_m;
                exc_q <= int_hit ? EXC_INT : exccode;
            end
        end
    end

    // EPC: victim PC on entry, else mtc0 load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q <= '0;
        end else if (intreq) begin
            epc_q <= word_align(victim_pc);
        end else if (wr_epc) begin
            epc_q <= word_align(wdata);
        end
    end

    // mfc0 read mux; unmapped numbers read as zero
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_W'(CP0_SR): begin
                rdata[IM_HI:IM_LO] = im_q;
                rdata[SR_EXL]      = exl_q;
                rdata[SR_IE]       = ie_q;
            end
            ADDR_W'(CP0_CAUSE): begin
                rdata[CAUSE_BD]      = bd_q;
                rdata[IP_HI:IP_LO]   = ip_q;
                rdata[EXC_HI:EXC_LO] = exc_q;
            end
            ADDR_W'(CP0_EPC):  rdata = epc_q;
            ADDR_W'(CP0_PRID): rdata = PRID_VAL;
            default:           rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl: inputs change 1ns after the rising edge,
// outputs are compared mid-cycle.
module tb_cp0_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hwint;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        exc_valid;
    logic [4:0]  exccode;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        intreq;
    logic        exl;

    int errors = 0;
    int checks = 0;

    cp0_intr_ctrl dut (
        .clk(clk), .reset(reset), .hwint(hwint), .pc_m(pc_m), .bd_m(bd_m),
        .exc_valid(exc_valid), .exccode(exccode), .we(we), .addr(addr),
        .wdata(wdata), .eret(eret), .rdata(rdata), .epc(epc),
        .intreq(intreq), .exl(exl)
    );

    always #5 clk = ~clk;

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; wdata = '0;
    endtask

    // leave exception level with hwint quiet
    task automatic leave_exl();
        hwint = '0; exc_valid = 1'b0; eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        hwint = '0; pc_m = '0; bd_m = 1'b0; exc_valid = 1'b0; exccode = '0;
        we = 1'b0; addr = '0; wdata = '0; eret = 1'b0;
        tick(); tick();
        reset = 1'b1;
        mtc0(5'd12, 32'h0000_0401);
        addr = 5'd12; #1;
        checks++; if (rdata !== 32'h0000_0401) begin errors++; $display("FAIL sr_write got=%h exp=%h", rdata, 32'h0000_0401); end
        reset = 1'b0; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_sr got=%h exp=0", rdata); end
        addr = 5'd13; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_cause got=%h exp=0", rdata); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", epc); end
        checks++; if (intreq !== 1'b0 || exl !== 1'b0) begin errors++; $display("FAIL reset_out got=%b%b exp=00", intreq, exl); end
        tick();
        reset = 1'b1;
        addr = 5'd15; #1;
        checks++; if (rdata !== 32'h0000_2019) begin errors++; $display("FAIL prid got=%h exp=%h", rdata, 32'h0000_2019); end
        addr = 5'd7; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", rdata); end
        tick();
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001; pc_m = 32'h3010; bd_m = 1'b0; #1;
        checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL int_req got=%b exp=1", intreq); end
        tick();
        checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL int_exl_mask got=%b exp=0", intreq); end
        checks++; if (exl !== 1'b1 || epc !== 32'h3010) begin errors++; $display("FAIL int_entry exl=%b epc=%h exp 1/3010", exl, epc); end
        addr = 5'd13; #1;
        checks++; if (rdata !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got=%h exp=%h", rdata, 32'h0000_0400); end
        addr = 5'd12; #1;
        checks++; if (rdata !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got=%h exp=%h", rdata, 32'h0000_0403); end
        leave_exl();
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL int_eret got=%b exp=0", exl); end
    endtask

    task automatic test_exc_delay_slot();
        exc_valid = 1'b1; exccode = 5'd4; bd_m = 1'b1; pc_m = 32'h3024; #1;
        checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL exc_req got=%b exp=1", intreq); end
        tick();
        checks++; if (epc !== 32'h3020) begin errors++; $display("FAIL exc_epc got=%h exp=3020", epc); end
        addr = 5'd13; #1;
        checks++; if (rdata !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause got=%h exp=%h", rdata, 32'h8000_0010); end
        // still asserting an exception while EXL=1 must not re-enter
        checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL exc_under_exl got=%b exp=0", intreq); end
        bd_m = 1'b0;
        leave_exl();
    endtask

    task automatic test_int_exc_priority();
        mtc0(5'd12, 32'h0000_0801);
        hwint = 6'b000010; exc_valid = 1'b1; exccode = 5'd12; pc_m = 32'h4000; #1;
        checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL prio_req got=%b exp=1", intreq); end
        tick();
        exc_valid = 1'b0;
        addr = 5'd13; #1;
        checks++; if (rdata !== 32'h0000_0800) begin errors++; $display("FAIL prio_cause got=%h exp=%h", rdata, 32'h0000_0800); end
        checks++; if (epc !== 32'h4000) begin errors++; $display("FAIL prio_epc got=%h exp=4000", epc); end
        leave_exl();
    endtask

    task automatic test_eret_reentry();
        hwint = 6'b000010; pc_m = 32'h4100; #1;
        checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL re_first got=%b exp=1", intreq); end
        tick();
        eret = 1'b1; #1;
        checks++; if (intreq !== 1'b0 || exl !== 1'b1) begin errors++; $display("FAIL re_held req=%b exl=%b exp 0/1", intreq, exl); end
        tick();
        eret = 1'b0; #1;
        checks++; if (exl !== 1'b0) begin errors++; $display("FAIL re_exl got=%b exp=0", exl); end
        checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL re_again got=%b exp=1", intreq); end
        tick();
        checks++; if (exl !== 1'b1) begin errors++; $display("FAIL re_entry got=%b exp=1", exl); end
        leave_exl();
        // eret at EXL=0 has no effect
        eret = 1'b1; tick(); eret = 1'b0;
        checks++; if (exl !== 1'b0 || intreq !== 1'b0) begin errors++; $display("FAIL eret_idle exl=%b req=%b exp 0/0", exl, intreq); end
    endtask

    task automatic test_masked_conflict();
        mtc0(5'd12, 32'h0000_0001);
        hwint = 6'b100000; #1;
        checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL masked_req got=%b exp=0", intreq); end
        tick();
        addr = 5'd13; #1;
        checks++; if (rdata !== 32'h0000_8000) begin errors++; $display("FAIL masked_ip got=%h exp=%h", rdata, 32'h0000_8000); end
        mtc0(5'd12, 32'h0000_8001);
        pc_m = 32'h5550; we = 1'b1; addr = 5'd14; wdata = 32'h5000; #1;
        checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL conflict_req got=%b exp=1", intreq); end
        tick();
        we = 1'b0;
        checks++; if (epc !== 32'h5550) begin errors++; $display("FAIL conflict_epc got=%h exp=5550", epc); end
        leave_exl();
    endtask

    task automatic test_epc_edges();
        mtc0(5'd14, 32'h0000_1237);
        checks++; if (epc !== 32'h0000_1234) begin errors++; $display("FAIL epc_mtc0 got=%h exp=1234", epc); end
        exc_valid = 1'b1; exccode = 5'd10; bd_m = 1'b1; pc_m = 32'h0; tick();
        exc_valid = 1'b0; bd_m = 1'b0;
        checks++; if (epc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL epc_wrap got=%h exp=fffffffc", epc); end
        addr = 5'd13; #1;
        checks++; if (rdata !== 32'h8000_0028) begin errors++; $display("FAIL wrap_cause got=%h exp=%h", rdata, 32'h8000_0028); end
        leave_exl();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exc_delay_slot();
        test_int_exc_priority();
        test_eret_reentry();
        test_masked_conflict();
        test_epc_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
